// File: rtl/fir_coeff_loader.sv
// Write-side initiator for the FIR coefficient RAM port: streams coefficients
// into the bank RAMs and zero-fills the unused taps up to MAX_TAPS.
module fir_coeff_loader #(
  parameter int unsigned COEFF_W    = 16,
  parameter int unsigned MAX_TAPS   = 40,
  parameter int unsigned BANK_DEPTH = 10,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic               iClk_12M,
  input  logic               iRst,
  input  logic               iStart,
  input  logic [5:0]         iNumTaps,
  input  logic               iCoeffValid,
  input  logic [COEFF_W-1:0] iCoeffData,
  output logic               oCoeffReady,
  output logic               oCoeffiUpdateFlag,
  output logic               oCsnRam,
  output logic               oWrnRam,
  output logic [ADDR_W-1:0]  oAddrRam,
  output logic [COEFF_W-1:0] oWrDtRam,
  output logic [5:0]         oNumOfCoeff,
  output logic               oBusy,
  output logic               oDone,
  output logic               oErr
);

  localparam int unsigned IDX_W = 6;
  localparam logic [IDX_W-1:0]  MAX_N     = IDX_W'(MAX_TAPS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MAX_TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FILL   = 2'd2,
    FINISH = 2'd3
  } stateT;

  stateT              state, stateNxt;
  logic [IDX_W-1:0]   idx, idxNxt;
  logic [IDX_W-1:0]   numTaps, numTapsNxt;
  logic [ADDR_W-1:0]  bankAddr, bankAddrNxt;

  logic               readyNxt, flagNxt, busyNxt, csnNxt, wrnNxt, doneNxt, errNxt;
  logic [ADDR_W-1:0]  addrNxt;
  logic [COEFF_W-1:0] dataNxt;
  logic [IDX_W-1:0]   coeffIdxNxt;

  logic               doWrite;
  logic [COEFF_W-1:0] wrData;

  // State, counters and every output are registered here.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state             <= IDLE;
      idx               <= '0;
      numTaps           <= '0;
      bankAddr          <= '0;
      oCoeffReady       <= 1'b0;
      oCoeffiUpdateFlag <= 1'b0;
      oBusy             <= 1'b0;
      oCsnRam           <= 1'b1;
      oWrnRam           <= 1'b1;
      oAddrRam          <= '0;
      oWrDtRam          <= '0;
      oNumOfCoeff       <= '0;
      oDone             <= 1'b0;
      oErr              <= 1'b0;
    end else begin
      state             <= stateNxt;
      idx               <= idxNxt;
      numTaps           <= numTapsNxt;
      bankAddr          <= bankAddrNxt;
      oCoeffReady       <= readyNxt;
      oCoeffiUpdateFlag <= flagNxt;
      oBusy             <= busyNxt;
      oCsnRam           <= csnNxt;
      oWrnRam           <= wrnNxt;
      oAddrRam          <= addrNxt;
      oWrDtRam          <= dataNxt;
      oNumOfCoeff       <= coeffIdxNxt;
      oDone             <= doneNxt;
      oErr              <= errNxt;
    end
  end

  // Next-state and next-output decode; strobes idle high, address/data hold.
  always_comb begin
    stateNxt    = state;
    idxNxt      = idx;
    numTapsNxt  = numTaps;
    bankAddrNxt = bankAddr;
    readyNxt    = oCoeffReady;
    flagNxt     = oCoeffiUpdateFlag;
    busyNxt     = oBusy;
    csnNxt      = 1'b1;
    wrnNxt      = 1'b1;
    addrNxt     = oAddrRam;
    dataNxt     = oWrDtRam;
    coeffIdxNxt = oNumOfCoeff;
    doneNxt     = 1'b0;
    errNxt      = 1'b0;
    doWrite     = 1'b0;
    wrData      = '0;

    case (state)
      IDLE: begin
        if (iStart) begin
          if ((iNumTaps != '0) && (iNumTaps <= MAX_N)) begin
            numTapsNxt  = iNumTaps;
            idxNxt      = '0;
            bankAddrNxt = '0;
            readyNxt    = 1'b1;
            flagNxt     = 1'b1;
            busyNxt     = 1'b1;
            stateNxt    = LOAD;
          end else begin
            errNxt = 1'b1;
          end
        end
      end
      LOAD: begin
        if (iCoeffValid && oCoeffReady) begin
          doWrite = 1'b1;
          wrData  = iCoeffData;
          if (idx == (numTaps - IDX_W'(1))) begin
            readyNxt = 1'b0;
            stateNxt = (numTaps == MAX_N) ? FINISH : FILL;
          end
        end
      end
      FILL: begin
        doWrite = 1'b1;
        wrData  = '0;
        if (idx == LAST_IDX) begin
          stateNxt = FINISH;
        end
      end
      FINISH: begin
        flagNxt  = 1'b0;
        busyNxt  = 1'b0;
        doneNxt  = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase

    // Shared write slot: index and bank address advance together, address wraps per bank.
    if (doWrite) begin
      csnNxt      = 1'b0;
      wrnNxt      = 1'b0;
      addrNxt     = bankAddr;
      dataNxt     = wrData;
      coeffIdxNxt = idx;
      idxNxt      = idx + IDX_W'(1);
      bankAddrNxt = (bankAddr == LAST_ADDR) ? '0 : bankAddr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: full loads, gaps, rejects, reset and restart attempts.
module tb_fir_coeff_loader;

  logic        clk;
  logic        iRst;
  logic        iStart;
  logic [5:0]  iNumTaps;
  logic        iCoeffValid;
  logic [15:0] iCoeffData;
  logic        oCoeffReady;
  logic        oCoeffiUpdateFlag;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [3:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic [5:0]  oNumOfCoeff;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  int nAssert = 0;
  int nFail   = 0;
  int elapsed = 0;

  fir_coeff_loader dut (
    .iClk_12M          (clk),
    .iRst              (iRst),
    .iStart            (iStart),
    .iNumTaps          (iNumTaps),
    .iCoeffValid       (iCoeffValid),
    .iCoeffData        (iCoeffData),
    .oCoeffReady       (oCoeffReady),
    .oCoeffiUpdateFlag (oCoeffiUpdateFlag),
    .oCsnRam           (oCsnRam),
    .oWrnRam           (oWrnRam),
    .oAddrRam          (oAddrRam),
    .oWrDtRam          (oWrDtRam),
    .oNumOfCoeff       (oNumOfCoeff),
    .oBusy             (oBusy),
    .oDone             (oDone),
    .oErr              (oErr)
  );

  initial clk = 1'b0;
  always #41 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    elapsed++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] coefOf(input int kind, input int i);
    logic [15:0] pat [4];
    pat = '{16'h0003, 16'h0000, 16'hFFFA, 16'h0007};
    case (kind)
      0:       return pat[i % 4];
      1:       return 16'(16'h8100 + i);
      default: return 16'h01F4;
    endcase
  endfunction

  task automatic chkIdle(input string tag);
    chk({tag, "_csn"},   32'(oCsnRam), 32'd1);
    chk({tag, "_wrn"},   32'(oWrnRam), 32'd1);
    chk({tag, "_busy"},  32'(oBusy), 32'd0);
    chk({tag, "_flag"},  32'(oCoeffiUpdateFlag), 32'd0);
    chk({tag, "_ready"}, 32'(oCoeffReady), 32'd0);
  endtask

  // Full load of n coefficients; optional valid gap before beat gapBeat and a restart poke at pokeBeat.
  task automatic runLoad(input string tag, input int n, input int kind,
                         input int gapBeat, input int gapLen, input int pokeBeat);
    int t0;
    iNumTaps = 6'(n);
    iStart   = 1'b1;
    tick();
    t0       = elapsed;
    iStart   = 1'b0;
    iNumTaps = 6'd0;
    chk({tag, "_busy_t1"},  32'(oBusy), 32'd1);
    chk({tag, "_flag_t1"},  32'(oCoeffiUpdateFlag), 32'd1);
    chk({tag, "_ready_t1"}, 32'(oCoeffReady), 32'd1);
    chk({tag, "_csn_t1"},   32'(oCsnRam), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (k == gapBeat) begin
        iCoeffValid = 1'b0;
        for (int g = 0; g < gapLen; g++) begin
          tick();
          chk({tag, "_gap_csn"},   32'(oCsnRam), 32'd1);
          chk({tag, "_gap_wrn"},   32'(oWrnRam), 32'd1);
          chk({tag, "_gap_idx"},   32'(oNumOfCoeff), 32'(k - 1));
          chk({tag, "_gap_data"},  32'(oWrDtRam), 32'(coefOf(kind, k - 1)));
          chk({tag, "_gap_flag"},  32'(oCoeffiUpdateFlag), 32'd1);
          chk({tag, "_gap_ready"}, 32'(oCoeffReady), 32'd1);
        end
      end
      iCoeffValid = 1'b1;
      iCoeffData  = coefOf(kind, k);
      if (k == pokeBeat) begin
        iStart   = 1'b1;
        iNumTaps = 6'd7;
      end
      tick();
      iStart   = 1'b0;
      iNumTaps = 6'd0;
      chk({tag, "_ld_csn"},   32'(oCsnRam), 32'd0);
      chk({tag, "_ld_wrn"},   32'(oWrnRam), 32'd0);
      chk({tag, "_ld_data"},  32'(oWrDtRam), 32'(coefOf(kind, k)));
      chk({tag, "_ld_idx"},   32'(oNumOfCoeff), 32'(k));
      chk({tag, "_ld_addr"},  32'(oAddrRam), 32'(k % 10));
      chk({tag, "_ld_ready"}, 32'(oCoeffReady), (k < n - 1) ? 32'd1 : 32'd0);
      chk({tag, "_ld_err"},   32'(oErr), 32'd0);
    end
    iCoeffValid = 1'b0;
    iCoeffData  = 16'h0000;
    for (int k = n; k < 40; k++) begin
      tick();
      chk({tag, "_fill_csn"},  32'(oCsnRam), 32'd0);
      chk({tag, "_fill_wrn"},  32'(oWrnRam), 32'd0);
      chk({tag, "_fill_data"}, 32'(oWrDtRam), 32'd0);
      chk({tag, "_fill_idx"},  32'(oNumOfCoeff), 32'(k));
      chk({tag, "_fill_addr"}, 32'(oAddrRam), 32'(k % 10));
      chk({tag, "_fill_flag"}, 32'(oCoeffiUpdateFlag), 32'd1);
      chk({tag, "_fill_done"}, 32'(oDone), 32'd0);
    end
    tick();
    chk({tag, "_done"},     32'(oDone), 32'd1);
    chk({tag, "_done_lat"}, 32'(elapsed - t0), 32'(41 + gapLen));
    chkIdle({tag, "_fin"});
    tick();
    chk({tag, "_done_drop"}, 32'(oDone), 32'd0);
    chkIdle({tag, "_post"});
  endtask

  initial begin
    iRst        = 1'b1;
    iStart      = 1'b0;
    iNumTaps    = 6'd0;
    iCoeffValid = 1'b0;
    iCoeffData  = 16'h0000;
    tick();
    tick();
    chkIdle("rst");
    chk("rst_addr", 32'(oAddrRam), 32'd0);
    chk("rst_data", 32'(oWrDtRam), 32'd0);
    chk("rst_idx",  32'(oNumOfCoeff), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    chk("rst_err",  32'(oErr), 32'd0);
    iRst = 1'b0;
    tick();

    // N=33, continuous valid, mixed-sign data
    runLoad("n33", 33, 0, -1, 0, -1);

    // N=5 with a 3-cycle valid gap between beats 1 and 2
    runLoad("n5gap", 5, 1, 2, 3, -1);

    // N=40, no fill phase
    runLoad("n40", 40, 2, -1, 0, -1);

    // Rejected starts: 0, 42 and the boundary 41
    for (int r = 0; r < 3; r++) begin
      iNumTaps = (r == 0) ? 6'd0 : (r == 1) ? 6'd42 : 6'd41;
      iStart   = 1'b1;
      tick();
      iStart   = 1'b0;
      chk("rej_err", 32'(oErr), 32'd1);
      chkIdle("rej");
      tick();
      chk("rej_err_drop", 32'(oErr), 32'd0);
      chkIdle("rej2");
    end

    // Reset after 12 beats of an N=33 load
    iNumTaps = 6'd33;
    iStart   = 1'b1;
    tick();
    iStart      = 1'b0;
    iCoeffValid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      iCoeffData = coefOf(1, k);
      tick();
      chk("mid_idx", 32'(oNumOfCoeff), 32'(k));
    end
    iRst = 1'b1;
    tick();
    iRst        = 1'b0;
    iCoeffValid = 1'b0;
    chkIdle("midrst");
    chk("midrst_idx",  32'(oNumOfCoeff), 32'd0);
    chk("midrst_addr", 32'(oAddrRam), 32'd0);
    chk("midrst_data", 32'(oWrDtRam), 32'd0);
    chk("midrst_done", 32'(oDone), 32'd0);
    tick();
    chkIdle("midrst2");
    chk("midrst2_done", 32'(oDone), 32'd0);

    // N=3 after the aborted load
    runLoad("n3", 3, 0, -1, 0, -1);

    // Restart attempt with N=7 during an N=33 load is ignored
    runLoad("poke", 33, 1, -1, 0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
